// File: rtl/pc_sequencer.sv
// Instruction sequencer: fetches from the address stage, fetches a memory operand
// for opcodes 1..7, and issues one exec_valid pulse per instruction.
module pc_sequencer #(
  parameter int AW       = 4,
  parameter int DW       = 8,
  parameter int ADDR_LAT = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic [DW-1:0] mem_data,
  output logic [AW-1:0] pc_addr,
  output logic [AW-1:0] op_addr,
  output logic          addr_sel,
  output logic          exec_valid,
  output logic [3:0]    exec_op,
  output logic [DW-1:0] exec_data,
  output logic          busy,
  output logic          halted
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    OPER  = 3'd2,
    EXEC  = 3'd3,
    HALT  = 3'd4
  } state_t;

  localparam logic [2:0] LAT = 3'(ADDR_LAT);

  state_t        state;
  logic [DW-1:0] ir;
  logic [2:0]    cnt;

  logic [3:0] fetched_op;
  logic       mem_operand;

  assign fetched_op  = mem_data[DW-1 -: 4];
  assign mem_operand = (fetched_op != 4'h0) && (fetched_op <= 4'h7);

  // pc_addr is the program counter itself; it only moves on the edge leaving EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc_addr    <= '0;
      op_addr    <= '0;
      addr_sel   <= 1'b0;
      exec_valid <= 1'b0;
      exec_op    <= 4'h0;
      exec_data  <= '0;
      busy       <= 1'b0;
      halted     <= 1'b0;
      ir         <= '0;
      cnt        <= 3'd0;
    end else begin
      exec_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (run) begin
            state    <= FETCH;
            cnt      <= LAT;
            addr_sel <= 1'b0;
            busy     <= 1'b1;
          end
        end

        FETCH: begin
          if (cnt == 3'd0) begin
            ir <= mem_data;
            if (mem_operand) begin
              op_addr  <= mem_data[AW-1:0];
              addr_sel <= 1'b1;
              cnt      <= LAT;
              state    <= OPER;
            end else begin
              exec_data  <= '0;
              exec_op    <= fetched_op;
              exec_valid <= 1'b1;
              state      <= EXEC;
            end
          end else begin
            cnt <= cnt - 3'd1;
          end
        end

        OPER: begin
          if (cnt == 3'd0) begin
            exec_data  <= mem_data;
            exec_op    <= ir[DW-1 -: 4];
            exec_valid <= 1'b1;
            addr_sel   <= 1'b0;
            state      <= EXEC;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end

        EXEC: begin
          if (ir[DW-1 -: 4] == 4'hF) begin
            state  <= HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            if (ir[DW-1 -: 4] == 4'h8) begin
              pc_addr <= ir[AW-1:0];
            end else begin
              pc_addr <= pc_addr + AW'(1);
            end
            if (run) begin
              state <= FETCH;
              cnt   <= LAT;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        HALT: begin
          if (!run) begin
            state  <= IDLE;
            halted <= 1'b0;
          end
        end

        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          halted   <= 1'b0;
          addr_sel <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a 16-byte memory behind an ADDR_LAT-deep pipeline.
module tb_pc_sequencer;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int ADDR_LAT = 3;

  logic          clk;
  logic          rst_n;
  logic          run;
  logic [DW-1:0] mem_data;
  logic [AW-1:0] pc_addr;
  logic [AW-1:0] op_addr;
  logic          addr_sel;
  logic          exec_valid;
  logic [3:0]    exec_op;
  logic [DW-1:0] exec_data;
  logic          busy;
  logic          halted;

  int tests  = 0;
  int failed = 0;

  logic [DW-1:0] mem  [16];
  logic [DW-1:0] pipe [ADDR_LAT];
  logic [AW-1:0] sel_addr;

  pc_sequencer #(.AW(AW), .DW(DW), .ADDR_LAT(ADDR_LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .mem_data   (mem_data),
    .pc_addr    (pc_addr),
    .op_addr    (op_addr),
    .addr_sel   (addr_sel),
    .exec_valid (exec_valid),
    .exec_op    (exec_op),
    .exec_data  (exec_data),
    .busy       (busy),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Address stage + memory: data appears ADDR_LAT cycles after the address is presented.
  assign sel_addr = addr_sel ? op_addr : pc_addr;
  always @(posedge clk) begin
    pipe[0] <= mem[sel_addr];
    for (int i = 1; i < ADDR_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_data = pipe[ADDR_LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pc"},    32'(pc_addr),    32'h0);
    chk({tag, "_op"},    32'(op_addr),    32'h0);
    chk({tag, "_sel"},   32'(addr_sel),   32'h0);
    chk({tag, "_ev"},    32'(exec_valid), 32'h0);
    chk({tag, "_eop"},   32'(exec_op),    32'h0);
    chk({tag, "_edat"},  32'(exec_data),  32'h0);
    chk({tag, "_busy"},  32'(busy),       32'h0);
    chk({tag, "_halt"},  32'(halted),     32'h0);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
  endtask

  initial begin
    rst_n = 1'b0;
    run   = 1'b1;
    clear_mem();
    for (int i = 0; i < ADDR_LAT; i++) pipe[i] = 8'h00;

    // Reset held with run=1
    step(3);
    chk_reset_outputs("reset");

    // Release: next cycle is FETCH cycle 1 at PC 0
    rst_n = 1'b1;
    step(1);
    chk("rel_busy", 32'(busy), 32'h1);
    chk("rel_pc",   32'(pc_addr), 32'h0);
    chk("rel_sel",  32'(addr_sel), 32'h0);

    // NOP stream: 5 cycles per instruction, PC wraps 15 -> 0
    for (int i = 0; i < 17; i++) begin
      chk("nop_pc", 32'(pc_addr), 32'(i % 16));
      step(3);
      chk("nop_ev_lo", 32'(exec_valid), 32'h0);
      chk("nop_pc_hold", 32'(pc_addr), 32'(i % 16));
      step(1);
      chk("nop_ev", 32'(exec_valid), 32'h1);
      chk("nop_edat", 32'(exec_data), 32'h0);
      chk("nop_eop", 32'(exec_op), 32'h0);
      step(1);
    end

    // Memory-operand instruction
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst2");
    mem[0]  = 8'h3A;
    mem[10] = 8'h5C;
    step(2);
    rst_n = 1'b1;
    step(1);                                  // cycle 1
    chk("opr_c1_pc", 32'(pc_addr), 32'h0);
    chk("opr_c1_sel", 32'(addr_sel), 32'h0);
    step(3);                                  // cycle 4
    chk("opr_c4_sel", 32'(addr_sel), 32'h0);
    step(1);                                  // cycle 5
    chk("opr_c5_sel", 32'(addr_sel), 32'h1);
    chk("opr_c5_oaddr", 32'(op_addr), 32'hA);
    chk("opr_c5_ev", 32'(exec_valid), 32'h0);
    step(3);                                  // cycle 8
    chk("opr_c8_sel", 32'(addr_sel), 32'h1);
    chk("opr_c8_oaddr", 32'(op_addr), 32'hA);
    chk("opr_c8_ev", 32'(exec_valid), 32'h0);
    step(1);                                  // cycle 9
    chk("opr_ev", 32'(exec_valid), 32'h1);
    chk("opr_eop", 32'(exec_op), 32'h3);
    chk("opr_edat", 32'(exec_data), 32'h5C);
    chk("opr_exec_sel", 32'(addr_sel), 32'h0);
    step(1);                                  // next FETCH
    chk("opr_next_pc", 32'(pc_addr), 32'h1);
    chk("opr_ev_drop", 32'(exec_valid), 32'h0);
    chk("opr_edat_hold", 32'(exec_data), 32'h5C);
    chk("opr_eop_hold", 32'(exec_op), 32'h3);
    step(4);                                  // NOP at 1 executes
    chk("opr_nop_ev", 32'(exec_valid), 32'h1);
    chk("opr_nop_edat", 32'(exec_data), 32'h0);
    chk("opr_nop_eop", 32'(exec_op), 32'h0);

    // Jump then halt
    rst_n = 1'b0;
    clear_mem();
    mem[0] = 8'h86;
    mem[6] = 8'hF0;
    step(2);
    rst_n = 1'b1;
    step(1);                                  // cycle 1
    step(4);                                  // cycle 5
    chk("jmp_ev", 32'(exec_valid), 32'h1);
    chk("jmp_eop", 32'(exec_op), 32'h8);
    step(1);
    chk("jmp_pc", 32'(pc_addr), 32'h6);
    step(4);
    chk("hlt_ev", 32'(exec_valid), 32'h1);
    chk("hlt_eop", 32'(exec_op), 32'hF);
    step(1);
    chk("hlt_halted", 32'(halted), 32'h1);
    chk("hlt_busy", 32'(busy), 32'h0);
    chk("hlt_ev_lo", 32'(exec_valid), 32'h0);
    step(5);
    chk("hlt_stay", 32'(halted), 32'h1);
    chk("hlt_pc", 32'(pc_addr), 32'h6);
    chk("hlt_sel", 32'(addr_sel), 32'h0);
    run = 1'b0;
    step(1);
    chk("idle_halted", 32'(halted), 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);
    step(2);
    chk("idle_pc", 32'(pc_addr), 32'h6);
    run = 1'b1;
    step(1);
    chk("resume_busy", 32'(busy), 32'h1);
    chk("resume_pc", 32'(pc_addr), 32'h6);

    // Reset during cycle 2 of OPER
    rst_n = 1'b0;
    clear_mem();
    mem[0]  = 8'h3A;
    mem[10] = 8'h5C;
    step(2);
    rst_n = 1'b1;
    step(1);                                  // cycle 1
    step(5);                                  // cycle 6 = OPER cycle 2
    chk("mid_sel_pre", 32'(addr_sel), 32'h1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("mid_no_ev", 32'(exec_valid), 32'h0);
    end
    clear_mem();
    rst_n = 1'b1;
    step(1);
    chk("mid_restart_pc", 32'(pc_addr), 32'h0);
    chk("mid_restart_busy", 32'(busy), 32'h1);
    chk("mid_restart_sel", 32'(addr_sel), 32'h0);

    // Drop run during FETCH of the instruction at PC 2
    step(10);                                 // cycle 11: FETCH at PC 2
    chk("drop_pc", 32'(pc_addr), 32'h2);
    step(1);
    run = 1'b0;
    step(3);                                  // cycle 15: EXEC
    chk("drop_ev", 32'(exec_valid), 32'h1);
    step(1);
    chk("drop_busy", 32'(busy), 32'h0);
    chk("drop_pc_next", 32'(pc_addr), 32'h3);
    step(6);
    chk("drop_pc_held", 32'(pc_addr), 32'h3);
    chk("drop_ev_lo", 32'(exec_valid), 32'h0);
    chk("drop_idle_busy", 32'(busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
